// File: rtl/uart_tx_engine_pkg.sv
// Shared types and limits for the UART transmit path.
package uart_types;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } uart_parity_t;

  // The reserved encoding 3 behaves exactly like "no parity".
  function automatic uart_parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fsm_gen.sv
// Frame sequencer: state register, data-bit and stop-bit counters.
module uart_tx_fsm_gen
  import uart_types::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           baud_tick_i,
  input  logic           accept_i,
  input  logic           parity_en_i,
  input  logic           stop2_i,
  output uart_tx_state_t state_o,
  output uart_tx_state_t state_d_o,
  output logic           shift_en_o,
  output logic           tx_done_o
);

  localparam int unsigned         CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_BITS - 1);

  uart_tx_state_t   state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             done_q, done_d;

  // Next-state logic; everything except the accept step waits for a baud tick.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_en_o = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_i) state_d = START_BIT;
      end
      START_BIT: begin
        if (baud_tick_i) begin
          state_d   = uart_types::DATA_BITS;
          bit_cnt_d = '0;
        end
      end
      uart_types::DATA_BITS: begin
        if (baud_tick_i) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = parity_en_i ? PARITY_BIT : STOP_BIT;
            stop_cnt_d = 1'b0;
          end else begin
            shift_en_o = 1'b1;
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY_BIT: begin
        if (baud_tick_i) begin
          state_d    = STOP_BIT;
          stop_cnt_d = 1'b0;
        end
      end
      STOP_BIT: begin
        if (baud_tick_i) begin
          if (stop2_i && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d    = IDLE;
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and the registered completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      done_q     <= done_d;
    end
  end

  assign state_o   = state_q;
  assign state_d_o = state_d;
  assign tx_done_o = done_q;

endmodule

// File: rtl/uart_tx_engine.sv
// Parametrised UART transmitter: handshake, shift register, parity and line driver.
module uart_tx_engine
  import uart_types::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done,
  output uart_tx_state_t       state
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_width
    $error("uart_tx_engine: DATA_BITS must lie in 5..9");
  end

  uart_tx_state_t       state_d;
  logic                 shift_en;
  logic                 accept;
  uart_parity_t         par_sel;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 parity_en_q, parity_en_d;
  logic                 stop2_q, stop2_d;
  logic                 txd_q, txd_d;

  assign accept  = tx_valid && tx_ready;
  assign par_sel = decode_parity(parity_mode);

  uart_tx_fsm_gen #(
    .DATA_BITS (DATA_BITS)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick_i (baud_tick),
    .accept_i    (accept),
    .parity_en_i (parity_en_q),
    .stop2_i     (stop2_q),
    .state_o     (state),
    .state_d_o   (state_d),
    .shift_en_o  (shift_en),
    .tx_done_o   (tx_done)
  );

  // Latch payload and frame config on accept; shift while data bits go out.
  // txd is derived from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    shift_d     = shift_q;
    par_d       = par_q;
    parity_en_d = parity_en_q;
    stop2_d     = stop2_q;
    if (accept) begin
      shift_d     = tx_data;
      par_d       = (par_sel == PAR_ODD) ? ~(^tx_data) : (^tx_data);
      parity_en_d = (par_sel != PAR_NONE);
      stop2_d     = stop2;
    end else if (shift_en) begin
      shift_d = shift_q >> 1;
    end
    unique case (state_d)
      START_BIT:             txd_d = 1'b0;
      uart_types::DATA_BITS: txd_d = shift_d[0];
      PARITY_BIT:            txd_d = par_q;
      default:               txd_d = IDLE_LEVEL;
    endcase
  end

  // Datapath registers; txd falls back to the idle level the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      par_q       <= 1'b0;
      parity_en_q <= 1'b0;
      stop2_q     <= 1'b0;
      txd_q       <= IDLE_LEVEL;
    end else begin
      shift_q     <= shift_d;
      par_q       <= par_d;
      parity_en_q <= parity_en_d;
      stop2_q     <= stop2_d;
      txd_q       <= txd_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: an 8-bit and a 7-bit instance.
module tb_uart_tx_engine;
  import uart_types::*;

  typedef struct {
    logic [15:0] bits;
    int unsigned len;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_tick = 1'b0;
  logic [7:0] data8 = '0;
  logic [6:0] data7 = '0;
  logic valid8 = 1'b0;
  logic valid7 = 1'b0;
  logic [1:0] pmode = '0;
  logic s2 = 1'b0;

  logic ready8, busy8, done8, txd8;
  logic ready7, busy7, done7, txd7;
  uart_tx_state_t st8, st7;

  int n_checks = 0;
  int n_errors = 0;
  frame_t q8[$];
  frame_t q7[$];

  logic [15:0] col8, col7;
  int unsigned n8 = 0, n7 = 0;
  int unsigned idle8 = 0, gap8 = 0;
  logic prev8 = 1'b0;

  uart_tx_engine #(.DATA_BITS(8), .IDLE_LEVEL(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data8),
    .tx_valid(valid8), .tx_ready(ready8), .parity_mode(pmode), .stop2(s2),
    .txd(txd8), .tx_busy(busy8), .tx_done(done8), .state(st8)
  );

  uart_tx_engine #(.DATA_BITS(7), .IDLE_LEVEL(1'b1)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(data7),
    .tx_valid(valid7), .tx_ready(ready7), .parity_mode(pmode), .stop2(s2),
    .txd(txd7), .tx_busy(busy7), .tx_done(done7), .state(st7)
  );

  always #5 clk = ~clk;

  // Reference: start 0, data LSB first, optional parity from a ones count, 1 or 2 stop 1s.
  function automatic frame_t model(input logic [8:0] d, input int unsigned nb,
                                   input logic [1:0] pm, input logic st2);
    frame_t f;
    int unsigned ones;
    ones = 0;
    f.bits = '0;
    f.len = 0;
    f.bits[f.len] = 1'b0; f.len++;
    for (int unsigned i = 0; i < nb; i++) begin
      f.bits[f.len] = d[i]; f.len++;
      if (d[i]) ones++;
    end
    if (pm == 2'd1) begin f.bits[f.len] = (ones % 2 == 1); f.len++; end
    else if (pm == 2'd2) begin f.bits[f.len] = (ones % 2 == 0); f.len++; end
    f.bits[f.len] = 1'b1; f.len++;
    if (st2) begin f.bits[f.len] = 1'b1; f.len++; end
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_frame(input string name, input frame_t exp, input logic [15:0] got,
                               input int unsigned glen, input logic rdy, input logic bsy);
    logic ok;
    ok = (glen == exp.len);
    for (int unsigned i = 0; i < 16; i++)
      if (i < exp.len && got[i] !== exp.bits[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d bits %h expected %0d bits %h", name, glen, got, exp.len, exp.bits);
    end
    n_checks++;
    if (!(rdy === 1'b1 && bsy === 1'b0)) begin
      n_errors++;
      $display("FAIL %s_ready_at_done: got ready=%b busy=%b expected ready=1 busy=0", name, rdy, bsy);
    end
  endtask

  // Free-running baud generator with a jittered period.
  initial begin
    int unsigned gap;
    gap = 0;
    forever begin
      @(posedge clk); #2;
      if (gap == 0) begin
        baud_tick = 1'b1;
        gap = $urandom_range(2, 5);
      end else begin
        baud_tick = 1'b0;
        gap--;
      end
    end
  end

  // Monitor: collect the line level at every tick of a frame, score it on tx_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      n8 = 0;
      n7 = 0;
    end else begin
      if (busy8 && baud_tick && n8 < 16) begin col8[n8] = txd8; n8++; end
      if (busy7 && baud_tick && n7 < 16) begin col7[n7] = txd7; n7++; end
      if (done8) begin
        if (q8.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL frame8: got tx_done expected no frame pending");
        end else compare_frame("frame8", q8.pop_front(), col8, n8, ready8, busy8);
        n8 = 0;
      end
      if (done7) begin
        if (q7.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL frame7: got tx_done expected no frame pending");
        end else compare_frame("frame7", q7.pop_front(), col7, n7, ready7, busy7);
        n7 = 0;
      end
    end
    if (busy8 && !prev8) gap8 = idle8;
    idle8 = busy8 ? 0 : idle8 + 1;
    prev8 = busy8;
  end

  task automatic send(input int unsigned k, input logic [8:0] d, input logic [1:0] pm,
                      input logic st2, input bit hold);
    int unsigned guard;
    logic rdy;
    guard = 0;
    @(posedge clk); #2;
    pmode = pm;
    s2 = st2;
    if (k == 0) begin data8 = d[7:0]; valid8 = 1'b1; end
    else begin data7 = d[6:0]; valid7 = 1'b1; end
    do begin
      @(negedge clk);
      guard++;
      rdy = (k == 0) ? ready8 : ready7;
    end while (!rdy && guard < 5000);
    if (!rdy) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 5000 cycles");
      valid8 = 1'b0; valid7 = 1'b0;
      return;
    end
    if (k == 0) q8.push_back(model(d, 8, pm, st2));
    else q7.push_back(model(d, 7, pm, st2));
    @(posedge clk); #2;
    if (!hold) begin valid8 = 1'b0; valid7 = 1'b0; end
    pmode = 2'($urandom_range(0, 3));
    s2 = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int unsigned guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((q8.size() != 0 || q7.size() != 0 || busy8 || busy7) && guard < 6000);
    if (guard >= 6000) begin
      n_checks++; n_errors++;
      $display("FAIL idle_timeout: got pending=%0d/%0d expected 0/0", q8.size(), q7.size());
      q8.delete(); q7.delete();
    end
  endtask

  initial begin
    int unsigned guard;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd8), 32'd1);
    chk("rst_ready", 32'(ready8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_state", 32'(st8), 32'(IDLE));
    @(posedge clk); #2;
    rst_n = 1'b1;

    send(0, 9'h0A5, 2'd0, 1'b0, 1'b0); wait_idle();
    send(0, 9'h0A5, 2'd1, 1'b1, 1'b0); wait_idle();
    send(0, 9'h0A5, 2'd2, 1'b1, 1'b0); wait_idle();
    send(1, 9'h07F, 2'd2, 1'b0, 1'b0); wait_idle();
    send(0, 9'h0A5, 2'd3, 1'b0, 1'b0); wait_idle();

    // Back-to-back with tx_valid held high.
    send(0, 9'h001, 2'd0, 1'b0, 1'b1);
    send(0, 9'h080, 2'd0, 1'b0, 1'b0);
    wait_idle();
    chk("b2b_gap", 32'(gap8), 32'd1);

    // Reset in the middle of the data bits.
    send(0, 9'h03C, 2'd1, 1'b1, 1'b0);
    guard = 0;
    while (st8 != uart_types::DATA_BITS && guard < 2000) begin @(negedge clk); guard++; end
    chk("reach_data_bits", 32'(st8 == uart_types::DATA_BITS), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd8), 32'd1);
    chk("midrst_state", 32'(st8), 32'(IDLE));
    chk("midrst_ready", 32'(ready8), 32'd1);
    q8.delete();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    send(0, 9'h0C3, 2'd2, 1'b0, 1'b0); wait_idle();

    // Ticks while idle must not disturb the line or state.
    repeat (20) begin
      @(negedge clk);
      chk("idle_txd", 32'(txd8), 32'd1);
      chk("idle_state", 32'(st8), 32'(IDLE));
    end

    repeat (30) send(0, 9'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
    valid8 = 1'b0;
    wait_idle();
    repeat (8) send(1, 9'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
